// File: rtl/fft_pkg.sv
// fft_pkg: shared state encoding and core array layout helper for the FFT frame sequencer.
package fft_pkg;

    typedef enum logic [1:0] {LOAD, COMPUTE, UNLOAD} seq_state_t;

    // Bit offset of element k in a packed {re, im} array whose components are ew bits wide.
    function automatic int elem_lo(input int k, input int ew);
        return 2 * k * ew;
    endfunction

endpackage

// File: rtl/fft_result_buffer.sv
// fft_result_buffer: N-entry capture register of packed complex results with an indexed read mux.
module fft_result_buffer
    import fft_pkg::*;
#(
    parameter int N  = 16,
    parameter int OW = 32,
    parameter int IW = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              capture_i,
    input  logic [N*2*OW-1:0] data_i,
    input  logic [IW-1:0]     idx_i,
    output logic [OW-1:0]     re_o,
    output logic [OW-1:0]     im_o
);

    logic [N*2*OW-1:0] buf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) buf_q <= '0;
        else if (capture_i) buf_q <= data_i;
    end

    assign {re_o, im_o} = buf_q[elem_lo(int'(idx_i), OW) +: 2*OW];

endmodule

// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer: loads one frame into the combinational FFT core, waits SETTLE cycles,
// captures the result and streams it out in index order.
module fft_frame_sequencer
    import fft_pkg::*;
#(
    parameter int N      = 16,
    parameter int W      = 16,
    parameter int SETTLE = 2,
    parameter int IW     = $clog2(N)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [W-1:0]          in_re,
    input  logic [W-1:0]          in_im,
    input  logic                  in_inverse,
    output logic [N*2*W-1:0]      core_x,
    output logic                  core_sel,
    input  logic [N*2*(W+N)-1:0]  core_X,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [W+N-1:0]        out_re,
    output logic [W+N-1:0]        out_im,
    output logic [IW-1:0]         out_index,
    output logic                  out_last,
    output logic                  busy
);

    localparam int SW = $clog2(SETTLE + 1);

    seq_state_t        state_q, state_d;
    logic [IW-1:0]     load_q, load_d, oidx_q, oidx_d;
    logic [SW-1:0]     settle_q, settle_d;
    logic              sel_q, sel_d;
    logic [N*2*W-1:0]  core_x_q;
    logic              ld_en, capture;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= LOAD;
            load_q   <= '0;
            oidx_q   <= '0;
            settle_q <= '0;
            sel_q    <= 1'b0;
            core_x_q <= '0;
        end else begin
            state_q  <= state_d;
            load_q   <= load_d;
            oidx_q   <= oidx_d;
            settle_q <= settle_d;
            sel_q    <= sel_d;
            if (ld_en) core_x_q[elem_lo(int'(load_q), W) +: 2*W] <= {in_re, in_im};
        end
    end

    always_comb begin
        state_d  = state_q;
        load_d   = load_q;
        oidx_d   = oidx_q;
        settle_d = settle_q;
        sel_d    = sel_q;
        ld_en    = 1'b0;
        capture  = 1'b0;
        // flush wins over any handshake in the same cycle
        if (flush) begin
            state_d  = LOAD;
            load_d   = '0;
            oidx_d   = '0;
            settle_d = '0;
            sel_d    = 1'b0;
        end else begin
            case (state_q)
                LOAD: if (in_valid) begin
                    ld_en  = 1'b1;
                    load_d = load_q + 1'b1;
                    sel_d  = (load_q == '0) ? in_inverse : sel_q;
                    if (load_q == IW'(N-1)) begin
                        state_d  = COMPUTE;
                        settle_d = '0;
                    end
                end
                COMPUTE: begin
                    settle_d = settle_q + 1'b1;
                    if (settle_q == SW'(SETTLE-1)) begin
                        capture = 1'b1;
                        state_d = UNLOAD;
                        oidx_d  = '0;
                    end
                end
                UNLOAD: if (out_ready) begin
                    oidx_d  = oidx_q + 1'b1;
                    state_d = (oidx_q == IW'(N-1)) ? LOAD : UNLOAD;
                end
                default: state_d = LOAD;
            endcase
        end
    end

    assign in_ready  = (state_q == LOAD);
    assign out_valid = (state_q == UNLOAD);
    assign busy      = (state_q != LOAD);
    assign out_index = oidx_q;
    assign out_last  = out_valid && (oidx_q == IW'(N-1));
    assign core_x    = core_x_q;
    assign core_sel  = sel_q;

    fft_result_buffer #(.N(N), .OW(W+N), .IW(IW)) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .capture_i (capture),
        .data_i    (core_X),
        .idx_i     (oidx_q),
        .re_o      (out_re),
        .im_o      (out_im)
    );

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// tb_fft_frame_sequencer: directed scenarios around a 4-point reference DFT core model.
module tb_fft_frame_sequencer;

    localparam int N = 4, W = 16, SETTLE = 2, IW = 2, OW = W + N;

    logic              clk, rst_n, flush, in_valid, in_ready, in_inverse;
    logic [W-1:0]      in_re, in_im;
    logic [N*2*W-1:0]  core_x;
    logic              core_sel;
    logic [N*2*OW-1:0] core_X;
    logic              out_valid, out_ready, out_last, busy;
    logic [OW-1:0]     out_re, out_im;
    logic [IW-1:0]     out_index;
    int                tests = 0, fails = 0;

    fft_frame_sequencer #(.N(N), .W(W), .SETTLE(SETTLE), .IW(IW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_re(in_re), .in_im(in_im), .in_inverse(in_inverse), .core_x(core_x),
        .core_sel(core_sel), .core_X(core_X), .out_valid(out_valid), .out_ready(out_ready),
        .out_re(out_re), .out_im(out_im), .out_index(out_index), .out_last(out_last), .busy(busy)
    );

    // Reference core: exact 4-point DFT, inverse normalised by 1/N.
    function automatic logic [N*2*OW-1:0] dft(input logic [N*2*W-1:0] x, input logic inv);
        logic [N*2*OW-1:0] r;
        int ar, ai, a, b, m;
        r = '0;
        for (int k = 0; k < N; k++) begin
            ar = 0; ai = 0;
            for (int n = 0; n < N; n++) begin
                a = int'($signed(x[n*2*W+W +: W]));
                b = int'($signed(x[n*2*W +: W]));
                m = (n * k) % 4;
                if (inv) m = (4 - m) % 4;
                case (m)
                    0: begin ar += a; ai += b; end
                    1: begin ar += b; ai -= a; end
                    2: begin ar -= a; ai -= b; end
                    default: begin ar -= b; ai += a; end
                endcase
            end
            if (inv) begin ar /= 4; ai /= 4; end
            r[k*2*OW +: 2*OW] = {OW'(ar), OW'(ai)};
        end
        return r;
    endfunction

    assign core_X = dft(core_x, core_sel);

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic send(input int re, input int im, input bit inv);
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL send_ready: got %b want 1", in_ready); end
        in_valid = 1; in_re = W'(re); in_im = W'(im); in_inverse = inv;
        @(posedge clk); #1;
        in_valid = 0; in_inverse = 0;
    endtask

    task automatic send_frame(input int re[4], input int im[4], input bit inv0);
        for (int i = 0; i < 4; i++) send(re[i], im[i], i == 0 ? inv0 : 1'b0);
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 20) begin
            tests++;
            if (in_ready !== 1'b0) begin fails++; $display("FAIL busy_ready: got %b want 0", in_ready); end
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic recv(input int er[4], input int ei[4], input bit bp);
        int cnt = 0, cyc = 0;
        bit stalled = 0;
        logic [OW-1:0] pr, pi;
        logic [IW-1:0] px;
        while (cnt < 4 && cyc < 40) begin
            out_ready = bp ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'b1;
            tests++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
                fails++; $display("FAIL unload_flags: valid=%b ready=%b want 1/0", out_valid, in_ready);
            end
            if (stalled) begin
                tests++;
                if (out_re !== pr || out_im !== pi || out_index !== px) begin
                    fails++; $display("FAIL stall_hold: got %0d/%0d/%0d want %0d/%0d/%0d",
                                      out_re, out_im, out_index, pr, pi, px);
                end
            end
            if (out_ready) begin
                tests++;
                if (out_re !== OW'(er[cnt]) || out_im !== OW'(ei[cnt]) || out_index !== IW'(cnt)
                    || out_last !== (cnt == 3)) begin
                    fails++; $display("FAIL result%0d: got re=%0d im=%0d idx=%0d last=%b want %0d %0d %0d %b",
                                      cnt, $signed(out_re), $signed(out_im), out_index, out_last,
                                      er[cnt], ei[cnt], cnt, cnt == 3);
                end
                cnt++; stalled = 0;
            end else begin
                stalled = 1; pr = out_re; pi = out_im; px = out_index;
            end
            @(posedge clk); #1;
            cyc++;
        end
        out_ready = 1;
        tests++;
        if (cnt != 4 || out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            fails++; $display("FAIL frame_end: cnt=%0d valid=%b ready=%b busy=%b want 4/0/1/0",
                              cnt, out_valid, in_ready, busy);
        end
    endtask

    task automatic test_reset();
        tests++;
        if (core_x !== '0 || core_sel !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL reset_state: x=%h sel=%b valid=%b last=%b busy=%b want 0",
                              core_x, core_sel, out_valid, out_last, busy);
        end
        @(posedge clk); #1;
        rst_n = 1;
        tests++;
        if (in_ready !== 1'b1 || out_index !== '0) begin
            fails++; $display("FAIL reset_ready: ready=%b idx=%0d want 1/0", in_ready, out_index);
        end
    endtask

    task automatic test_impulse();
        int lat;
        send_frame('{1, 0, 0, 0}, '{0, 0, 0, 0}, 0);
        wait_valid(lat);
        tests++;
        if (lat != SETTLE + 1) begin fails++; $display("FAIL latency: got %0d want %0d", lat, SETTLE + 1); end
        recv('{1, 1, 1, 1}, '{0, 0, 0, 0}, 0);
    endtask

    task automatic test_constant();
        int lat;
        send_frame('{1, 1, 1, 1}, '{0, 0, 0, 0}, 0);
        wait_valid(lat);
        recv('{4, 0, 0, 0}, '{0, 0, 0, 0}, 0);
    endtask

    task automatic test_inverse();
        int lat;
        send_frame('{4, 0, 0, 0}, '{0, 0, 0, 0}, 1);
        wait_valid(lat);
        tests++;
        if (core_sel !== 1'b1) begin fails++; $display("FAIL inverse_sel: got %b want 1", core_sel); end
        recv('{1, 1, 1, 1}, '{0, 0, 0, 0}, 0);
    endtask

    task automatic test_backpressure();
        int lat;
        send_frame('{1, 3, 5, 7}, '{2, 4, 6, 8}, 0);
        wait_valid(lat);
        recv('{16, -8, -4, 0}, '{20, 0, -4, -8}, 1);
    endtask

    task automatic test_flush();
        int lat;
        send(5, 0, 1);
        send(7, 0, 0);
        in_valid = 1; in_re = 16'd9; in_im = 0; flush = 1;
        @(posedge clk); #1;
        in_valid = 0; flush = 0;
        tests++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || core_sel !== 1'b0) begin
            fails++; $display("FAIL flush_load: ready=%b busy=%b sel=%b want 1/0/0", in_ready, busy, core_sel);
        end
        send_frame('{2, 2, 2, 2}, '{0, 0, 0, 0}, 0);
        wait_valid(lat);
        recv('{8, 0, 0, 0}, '{0, 0, 0, 0}, 0);
        send_frame('{4, 0, 0, 0}, '{0, 0, 0, 0}, 1);
        wait_valid(lat);
        out_ready = 1;
        @(posedge clk); #1;
        tests++;
        if (out_valid !== 1'b1 || out_index !== 2'd1 || core_sel !== 1'b1) begin
            fails++; $display("FAIL pre_flush: valid=%b idx=%0d sel=%b want 1/1/1", out_valid, out_index, core_sel);
        end
        flush = 1;
        @(posedge clk); #1;
        flush = 0;
        tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || core_sel !== 1'b0 || out_index !== '0) begin
            fails++; $display("FAIL flush_unload: valid=%b busy=%b ready=%b sel=%b idx=%0d want 0/0/1/0/0",
                              out_valid, busy, in_ready, core_sel, out_index);
        end
        tests++;
        if (core_x[31:0] !== 32'h0004_0000) begin
            fails++; $display("FAIL flush_keep_x: got %h want 00040000", core_x[31:0]);
        end
    endtask

    task automatic test_async_reset();
        int lat;
        send_frame('{1, 0, 0, 0}, '{0, 0, 0, 0}, 1);
        wait_valid(lat);
        tests++;
        if (out_valid !== 1'b1) begin fails++; $display("FAIL pre_reset_valid: got %b want 1", out_valid); end
        rst_n = 0;
        #2;
        tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || core_sel !== 1'b0) begin
            fails++; $display("FAIL async_reset: valid=%b busy=%b sel=%b want 0", out_valid, busy, core_sel);
        end
        #1 rst_n = 1;
        #1;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_index !== '0) begin
            fails++; $display("FAIL reset_release: valid=%b ready=%b idx=%0d want 0/1/0", out_valid, in_ready, out_index);
        end
        @(posedge clk); #1;
        send_frame('{1, 1, 1, 1}, '{0, 0, 0, 0}, 0);
        wait_valid(lat);
        recv('{4, 0, 0, 0}, '{0, 0, 0, 0}, 0);
    endtask

    initial begin
        rst_n = 0; flush = 0; in_valid = 0; in_re = 0; in_im = 0; in_inverse = 0; out_ready = 1;
        #3;
        test_reset();
        test_impulse();
        test_constant();
        test_inverse();
        test_backpressure();
        test_flush();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fft_frame_sequencer.md
Name: fft_frame_sequencer

Overview:
- Sequences the combinational FFT/iFFT core for frame-based processing.
- Collects N complex samples from a valid/ready stream and drives the core's parallel input array from stable registers.
- Selects forward or inverse transform per frame and waits a programmable number of settle cycles before sampling the core output.
- Captures the N complex results, then streams them out in index order with valid/ready and a last flag.

Parameters:
- N, 16, transform length (power of two, >=2); matches the core's N.
- W, 16, signed width of each input real/imag component; matches the core's W.
- SETTLE, 2, number of cycles the core inputs are held before the result is captured (>=1).
- IW, $clog2(N), width of the sample index counters.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- flush  input  1  synchronous abort; discards the current frame and returns to LOAD.
- in_valid  input  1  input sample valid.
- in_ready  output  1  sequencer can accept a sample.
- in_re  input  W  signed real part of the input sample.
- in_im  input  W  signed imaginary part of the input sample.
- in_inverse  input  1  transform select (1 = inverse); sampled with the frame's first sample.
- core_x  output  N*2*W  packed input array to the core; element k is at bits [(2k+2)*W-1 : 2k*W], with re in the upper half and im in the lower half.
- core_sel  output  1  forward/inverse select to the core.
- core_X  input  N*2*(W+N)  packed core result, same packing with element width W+N.
- out_valid  output  1  result sample valid.
- out_ready  input  1  downstream accepts the result sample.
- out_re  output  W+N  signed real part of the result.
- out_im  output  W+N  signed imaginary part of the result.
- out_index  output  IW  index k of the current result sample.
- out_last  output  1  high with out_valid when out_index = N-1.
- busy  output  1  high in COMPUTE and UNLOAD.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = LOAD; load index, settle counter and output index = 0.
  - core_x registers = 0; core_sel = 0; result buffer = 0.
  - in_ready = 1 once reset is released; out_valid = 0; out_last = 0; busy = 0.
- State LOAD:
  - in_ready = 1.
  - On in_valid & in_ready, write {in_re, in_im} to core_x element [load index], then increment the load index.
  - The sample at load index 0 also latches in_inverse into core_sel. core_sel is then held for the whole frame; in_inverse on later samples is ignored.
  - Accepting the sample at load index N-1 wraps the load index to 0 and moves to COMPUTE on the next edge, with the settle counter = 0.
- State COMPUTE:
  - in_ready = 0; core_x and core_sel are held stable.
  - The settle counter increments each cycle.
  - On the cycle where settle counter = SETTLE-1, capture all of core_X into the result buffer, then go to UNLOAD with the output index = 0.
  - Minimum latency from the last input handshake to the first out_valid = SETTLE+1 cycles.
- State UNLOAD:
  - out_valid = 1; out_re, out_im and out_index come from the result buffer at the output index (registered buffer, combinational mux).
  - On out_valid & out_ready, increment the output index.
  - The handshake at index N-1 (out_last = 1) moves to LOAD on the next edge; out_valid drops that edge.
  - If out_ready is low, all outputs are held stable (AXI-style; no combinational path from out_ready to out_valid).
- flush:
  - Has priority over every other event in the same cycle, including a simultaneous in or out handshake; that handshake is discarded.
  - Next state = LOAD; all counters = 0; out_valid = 0.
  - core_x contents are retained, not cleared; core_sel = 0.
- Arithmetic: no scaling or rounding in the sequencer. Results pass through at full W+N width. Inverse-transform normalisation is done in the core.
- Reset asserted mid-frame behaves exactly as power-on reset; partial frames are lost.
- Sample order in equals index order; out_index is strictly 0..N-1 per frame.

Decomposition:
- Shared package fft_pkg holds:
  - state enum seq_state_t {LOAD, COMPUTE, UNLOAD};
  - complex sample typedefs cplx_in_t (W) and cplx_out_t (W+N);
  - the pack/unpack functions for the core_x/core_X layout.
- One natural sub-module: fft_result_buffer (N-entry capture register with read mux), reused later by streaming variants.

Test Plan (N=4, W=16, SETTLE=2, bench core = behavioural reference DFT):
- Impulse: in = (1,0),(0,0),(0,0),(0,0), forward, out_ready=1 -> out = (1,0) x4; out_last only on index 3; first out_valid exactly 3 cycles after the 4th input handshake.
- Constant: four samples (1,0), forward -> out = (4,0),(0,0),(0,0),(0,0); in_ready = 0 from the cycle after the 4th accept until after the out_last handshake.
- Inverse select: first sample has in_inverse=1, later samples have in_inverse=0; in = (4,0),(0,0),(0,0),(0,0) -> core_sel = 1 for the whole frame; out = (1,0) x4.
- Backpressure: out_ready toggles 1,0,0,1,... -> out_re, out_im and out_index are stable while stalled; no sample is lost or duplicated; indices 0,1,2,3 are delivered in order.
- Flush: flush after 2 accepted samples, with a simultaneous in_valid -> that sample is discarded; next 4 samples (2,0) x4 -> out = (8,0),(0,0),(0,0),(0,0). Flush during UNLOAD at index 1 -> out_valid = 0 next cycle and state = LOAD.
- Async reset mid-UNLOAD: rst_n pulsed low between clock edges -> out_valid = 0 and in_ready = 1 immediately after release, without waiting for an edge; the next frame processes correctly.
